// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment display scheduler.
//   state_t   : scheduler FSM states
//   BLANK_PAT : raw-segment payload with every segment off
//   MODE_HEX / MODE_RAW : values of the seg7x16 disp_mode input
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW,
    ST_PIN
  } state_t;

  localparam logic [63:0] BLANK_PAT = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic        MODE_HEX  = 1'b0;
  localparam logic        MODE_RAW  = 1'b1;

endpackage

// File: rtl/seg7_rr_pick.sv
// Round-robin picker: returns the first enabled index after base, searching
// base+1 .. NSRC-1, 0 .. base (base itself is the last candidate).
//   en    : per-source enable
//   base  : index the search starts after
//   idx   : chosen index (equals base when nothing is enabled)
//   found : at least one source is enabled
module seg7_rr_pick #(
  parameter int NSRC  = 4,
  parameter int IDX_W = $clog2(NSRC)
) (
  input  logic [NSRC-1:0]  en,
  input  logic [IDX_W-1:0] base,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] k;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    idx   = base;
    found = 1'b0;
    k     = base;
    // Walk from the far end of the search order so the nearest hit wins.
    for (int i = NSRC; i >= 1; i--) begin
      k = IDX_W'((int'(base) + i) % NSRC);
      if (en[k]) begin
        idx   = k;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_disp_sched.sv
// Time-shares the 8-digit 7-segment display among NSRC requesters.
// One payload + mode is shown per dwell period, round-robin over enabled
// sources, with blank gaps between pages, a manual pin and a manual step.
//   clk, rst  : clock, synchronous active-high reset
//   src_data  : NSRC x 64-bit payloads, source k at [64k+63:64k]
//   src_mode  : per-source display mode (0 hex, 1 raw segments)
//   src_en    : per-source display request (level)
//   pin_req   : lock the display to pin_sel (level)
//   pin_sel   : pinned source index, clamped to NSRC-1
//   step      : one-cycle pulse, end the current page early
//   o_data, o_mode : to seg7x16 i_data / disp_mode
//   o_src     : index of the shown source
//   o_active  : a source payload (not blank) is driven
//   o_page    : pulse on the first cycle of each new page
module seg7_disp_sched
  import seg7_pkg::*;
#(
  parameter int NSRC  = 4,
  parameter int DWELL = 50000000,
  parameter int BLANK = 100000,
  parameter int CNT_W = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC*64-1:0] src_data,
  input  logic [NSRC-1:0]   src_mode,
  input  logic [NSRC-1:0]   src_en,
  input  logic              pin_req,
  input  logic [2:0]        pin_sel,
  input  logic              step,
  output logic [63:0]       o_data,
  output logic              o_mode,
  output logic [2:0]        o_src,
  output logic              o_active,
  output logic              o_page
);

  localparam int IDX_W = $clog2(NSRC);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] cur, cur_n, target, target_n;
  logic [IDX_W-1:0] pin_idx, pin_idx_q, base, pick_idx;
  logic             pin_q, pick_found;
  logic             pin_rise, pin_fall, pin_chg;
  logic             dwell_end, blank_end, page_n, show_n;
  logic [63:0]      data_n;
  logic             mode_n;

  assign pin_idx  = (int'(pin_sel) >= NSRC) ? IDX_W'(NSRC - 1) : pin_sel[IDX_W-1:0];
  assign pin_rise = pin_req & ~pin_q;
  assign pin_fall = ~pin_req & pin_q;
  assign pin_chg  = pin_req & pin_q & (pin_idx != pin_idx_q);

  // One picker serves every decision: after an unpin the search starts from
  // the pinned index, at blank end from the pending target, otherwise from cur.
  assign base = pin_fall ? pin_idx : (state == ST_BLANK) ? target : cur;

  seg7_rr_pick #(.NSRC(NSRC), .IDX_W(IDX_W)) u_pick (
    .en    (src_en),
    .base  (base),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // A step coinciding with dwell expiry is the same single page end.
  assign dwell_end = (cnt == CNT_W'(DWELL - 1)) || step;
  assign blank_end = (cnt == CNT_W'(BLANK - 1));

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    cur_n    = cur;
    target_n = target;
    page_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pin_req) begin
          state_n  = ST_BLANK;
          cnt_n    = '0;
          target_n = pin_idx;
        end else if (pick_found) begin
          state_n  = ST_BLANK;
          cnt_n    = '0;
          target_n = pick_idx;
        end
      end
      default: begin
        if (pin_rise || pin_chg) begin
          state_n  = ST_BLANK;
          cnt_n    = '0;
          target_n = pin_idx;
        end else if (pin_fall || (state == ST_SHOW && !src_en[cur])) begin
          // Losing the current source with nothing else enabled skips the gap.
          state_n  = pick_found ? ST_BLANK : ST_IDLE;
          cnt_n    = '0;
          target_n = pick_idx;
        end else if (state == ST_SHOW) begin
          if (dwell_end) begin
            cnt_n = '0;
            if (pick_idx != cur) begin
              state_n  = ST_BLANK;
              target_n = pick_idx;
            end else begin
              page_n = 1'b1;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end else if (state == ST_BLANK) begin
          if (blank_end) begin
            cnt_n  = '0;
            page_n = 1'b1;
            if (pin_req) begin
              state_n = ST_PIN;
              cur_n   = pin_idx;
            end else if (src_en[target]) begin
              state_n = ST_SHOW;
              cur_n   = target;
            end else if (pick_found) begin
              // Target was withdrawn during the gap; move on to the next one.
              state_n = ST_SHOW;
              cur_n   = pick_idx;
            end else begin
              state_n = ST_IDLE;
              page_n  = 1'b0;
            end
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        // ST_PIN holds cnt and ignores step.
      end
    endcase
  end

  // Outputs are registered from next state so they line up with the state
  // register; payload follows the live source inputs every cycle.
  assign show_n = (state_n == ST_SHOW) || (state_n == ST_PIN);
  assign data_n = show_n ? src_data[cur_n*64 +: 64] : BLANK_PAT;
  assign mode_n = show_n ? src_mode[cur_n] : MODE_RAW;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cur       <= '0;
      target    <= '0;
      pin_q     <= 1'b0;
      pin_idx_q <= '0;
      o_data    <= BLANK_PAT;
      o_mode    <= MODE_RAW;
      o_src     <= '0;
      o_active  <= 1'b0;
      o_page    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cur       <= cur_n;
      target    <= target_n;
      pin_q     <= pin_req;
      pin_idx_q <= pin_idx;
      o_data    <= data_n;
      o_mode    <= mode_n;
      o_src     <= 3'(cur_n);
      o_active  <= show_n;
      o_page    <= page_n;
    end
  end

endmodule

// File: tb/tb_seg7_disp_sched.sv
// Self-checking bench for seg7_disp_sched with NSRC=4, DWELL=8, BLANK=2.
module tb_seg7_disp_sched;
  import seg7_pkg::*;

  localparam int NSRC  = 4;
  localparam int DWELL = 8;
  localparam int BLANK = 2;
  localparam int CNT_W = 26;

  localparam logic [63:0] PAT0 = 64'h0000_1111_2222_3333;
  localparam logic [63:0] PAT1 = 64'h4444_5555_6666_7777;
  localparam logic [63:0] PAT2 = 64'h89AB_CDEF_0123_4567;
  localparam logic [63:0] PAT3 = 64'hDEAD_BEEF_CAFE_F00D;

  logic               clk = 1'b0;
  logic               rst;
  logic [NSRC*64-1:0] src_data;
  logic [NSRC-1:0]    src_mode;
  logic [NSRC-1:0]    src_en;
  logic               pin_req;
  logic [2:0]         pin_sel;
  logic               step;
  logic [63:0]        o_data;
  logic               o_mode;
  logic [2:0]         o_src;
  logic               o_active;
  logic               o_page;

  logic [63:0] pat [NSRC];
  assign src_data = {pat[3], pat[2], pat[1], pat[0]};

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] d3;
    logic        m3;
    logic [3:0]  en;
    logic [63:0] d0;
    logic [63:0] exp_data;
    logic        exp_mode;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  seg7_disp_sched #(
    .NSRC(NSRC), .DWELL(DWELL), .BLANK(BLANK), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .src_data (src_data),
    .src_mode (src_mode),
    .src_en   (src_en),
    .pin_req  (pin_req),
    .pin_sel  (pin_sel),
    .step     (step),
    .o_data   (o_data),
    .o_mode   (o_mode),
    .o_src    (o_src),
    .o_active (o_active),
    .o_page   (o_page)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // n cycles of one page (act=1, source src) or of blank (act=0).
  task automatic run_page(input string name, input int n, input logic act,
                          input int src, input logic first_page);
    for (int i = 0; i < n; i++) begin
      tick();
      check({name, " active"}, 64'(o_active), 64'(act));
      check({name, " page"}, 64'(o_page), 64'(act && first_page && (i == 0)));
      check({name, " data"}, o_data, act ? pat[src] : BLANK_PAT);
      check({name, " mode"}, 64'(o_mode), 64'(act ? src_mode[src] : MODE_RAW));
      if (act) check({name, " src"}, 64'(o_src), 64'(src));
    end
  endtask

  initial begin
    rst      = 1'b1;
    src_en   = '0;
    pin_req  = 1'b0;
    pin_sel  = '0;
    step     = 1'b0;
    src_mode = {MODE_HEX, MODE_RAW, MODE_RAW, MODE_HEX};
    pat[0] = PAT0; pat[1] = PAT1; pat[2] = PAT2; pat[3] = PAT3;

    // Live-payload vectors applied while pinned on source 3.
    vecs[0] = '{64'h0123_4567_89AB_CDEF, 1'b0, 4'b0011, PAT0, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[1] = '{64'hFFFF_0000_FFFF_0000, 1'b1, 4'b0000, PAT0, 64'hFFFF_0000_FFFF_0000, 1'b1};
    vecs[2] = '{64'h0000_0000_0000_0000, 1'b0, 4'b1111, 64'hAAAA_AAAA_AAAA_AAAA, 64'h0, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0001, 1'b1, 4'b1000, 64'h5555_5555_5555_5555, 64'h8000_0000_0000_0001, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0001, 1'b0, 4'b0101, 64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001, 1'b0};

    // 1: reset held, then idle with nothing enabled.
    run_page("t1 reset", 3, 1'b0, 0, 1'b0);
    check("t1 reset src", 64'(o_src), 64'd0);
    rst = 1'b0;
    run_page("t1 idle", 3, 1'b0, 0, 1'b0);

    // 2: two sources alternate; from cur=0 the first pick is 2.
    src_en = 4'b0101;
    run_page("t2 lead blank", 2, 1'b0, 0, 1'b0);
    run_page("t2 src2 a", 8, 1'b1, 2, 1'b1);
    run_page("t2 gap a", 2, 1'b0, 0, 1'b0);
    run_page("t2 src0", 8, 1'b1, 0, 1'b1);
    run_page("t2 gap b", 2, 1'b0, 0, 1'b0);
    run_page("t2 src2 b", 8, 1'b1, 2, 1'b1);
    run_page("t2 gap c", 2, 1'b0, 0, 1'b0);
    run_page("t2 src0 again", 1, 1'b1, 0, 1'b1);

    // 3: single source repaints without gaps.
    src_en = 4'b0010;
    run_page("t3 blank", 2, 1'b0, 0, 1'b0);
    for (int p = 0; p < 3; p++) run_page("t3 src1", 8, 1'b1, 1, 1'b1);

    // 4: step at cnt=3 ends the page; step during blank is dropped.
    src_en = 4'b0011;
    run_page("t4 blank", 2, 1'b0, 0, 1'b0);
    run_page("t4 src0 head", 4, 1'b1, 0, 1'b1);
    step = 1'b1;
    run_page("t4 step blank", 1, 1'b0, 0, 1'b0);
    step = 1'b0;
    run_page("t4 step blank2", 1, 1'b0, 0, 1'b0);
    run_page("t4 src1 full", 8, 1'b1, 1, 1'b1);
    run_page("t4 gap", 1, 1'b0, 0, 1'b0);
    step = 1'b1;
    run_page("t4 gap step", 1, 1'b0, 0, 1'b0);
    step = 1'b0;
    run_page("t4 src0 full", 8, 1'b1, 0, 1'b1);

    // 5: pin to disabled source 3 (beats the coincident dwell expiry).
    pin_req = 1'b1;
    pin_sel = 3'd3;
    run_page("t5 pin blank", 2, 1'b0, 0, 1'b0);
    run_page("t5 pin3", 2, 1'b1, 3, 1'b1);
    step = 1'b1;
    run_page("t5 pin3 step", 1, 1'b1, 3, 1'b0);
    step = 1'b0;
    run_page("t5 pin3 hold", 9, 1'b1, 3, 1'b0);
    pin_sel = 3'd7;
    run_page("t5 pin clamp", 3, 1'b1, 3, 1'b0);

    for (int v = 0; v < 5; v++) begin
      pat[3]      = vecs[v].d3;
      pat[0]      = vecs[v].d0;
      src_mode[3] = vecs[v].m3;
      src_en      = vecs[v].en;
      tick();
      check($sformatf("t5 vec%0d data", v), o_data, vecs[v].exp_data);
      check($sformatf("t5 vec%0d mode", v), 64'(o_mode), 64'(vecs[v].exp_mode));
      check($sformatf("t5 vec%0d active", v), 64'(o_active), 64'd1);
      check($sformatf("t5 vec%0d src", v), 64'(o_src), 64'd3);
      check($sformatf("t5 vec%0d page", v), 64'(o_page), 64'd0);
    end
    pat[0] = PAT0;
    pat[3] = PAT3;
    src_mode[3] = MODE_HEX;
    src_en = 4'b0011;

    pin_sel = 3'd1;
    run_page("t5 repin blank", 2, 1'b0, 0, 1'b0);
    run_page("t5 pin1", 3, 1'b1, 1, 1'b1);
    pin_sel = 3'd3;
    run_page("t5 repin3 blank", 2, 1'b0, 0, 1'b0);
    run_page("t5 pin3 again", 2, 1'b1, 3, 1'b1);
    pin_req = 1'b0;
    run_page("t5 unpin blank", 2, 1'b0, 0, 1'b0);
    run_page("t5 resume src0", 8, 1'b1, 0, 1'b1);
    run_page("t5 gap", 2, 1'b0, 0, 1'b0);
    run_page("t5 src1", 3, 1'b1, 1, 1'b1);

    // 6: current source withdrawn with nothing else -> idle, no gap.
    src_en = 4'b0000;
    run_page("t6 idle", 3, 1'b0, 0, 1'b0);
    src_en = 4'b0001;
    run_page("t6 blank", 2, 1'b0, 0, 1'b0);
    run_page("t6 src0", 3, 1'b1, 0, 1'b1);
    rst = 1'b1;
    run_page("t6 reset mid-page", 1, 1'b0, 0, 1'b0);
    check("t6 reset src", 64'(o_src), 64'd0);
    rst = 1'b0;
    run_page("t6 post-reset blank", 2, 1'b0, 0, 1'b0);
    run_page("t6 post-reset src0", 2, 1'b1, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
